// File: rtl/fs_pkg.sv
// Shared types and constants for the registered full subtractor and the
// borrow-chained datapaths built from it.
package fs_pkg;

    localparam int FS_DEFAULT_WIDTH = 1;
    localparam int FS_MAX_WIDTH     = 64;

    // Sized for the widest legal operand; narrower users take the low d bits.
    typedef struct packed {
        logic                    bout;
        logic [FS_MAX_WIDTH-1:0] d;
    } fs_result_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// Combinational 1-bit full-subtractor cell: d = a ^ b ^ bin, with borrow out
// when a is smaller than b + bin.
module full_subtractor_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);

    assign d_o    = a_i ^ b_i ^ bin_i;
    assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/full_subtractor_reg.sv
// Ripple-borrow subtractor {bout, d} = a - b - bin, registered with 1-cycle latency.
// Accepts one operand set per cycle and never stalls; d/bout hold when in_valid is low.
module full_subtractor_reg
    import fs_pkg::*;
#(
    parameter int WIDTH = FS_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    output logic [WIDTH-1:0] d,
    output logic             bout
);

    logic [WIDTH:0]   br;
    logic [WIDTH-1:0] d_d;
    logic             bout_d;

    logic [WIDTH-1:0] d_q;
    logic             bout_q;
    logic             out_valid_q;

    assign br[0] = bin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ripple
        full_subtractor_bit u_bit (
            .a_i    (a[i]),
            .b_i    (b[i]),
            .bin_i  (br[i]),
            .d_o    (d_d[i]),
            .bout_o (br[i+1])
        );
    end

    assign bout_d = br[WIDTH];

    // Reset wins over a coincident valid input, which is simply dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q         <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                d_q    <= d_d;
                bout_q <= bout_d;
            end
        end
    end

    assign d         = d_q;
    assign bout      = bout_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_full_subtractor_reg.sv
// Directed and random checks of full_subtractor_reg at WIDTH=1 and WIDTH=8.
module tb_full_subtractor_reg;

    logic       clk = 1'b0;
    logic       rst;

    logic       iv1, a1, b1, bin1;
    logic       ov1, d1, bout1;

    logic       iv8, bin8;
    logic [7:0] a8, b8;
    logic       ov8, bout8;
    logic [7:0] d8;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    full_subtractor_reg #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .a(a1), .b(b1), .bin(bin1),
        .out_valid(ov1), .d(d1), .bout(bout1)
    );

    full_subtractor_reg #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(iv8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .d(d8), .bout(bout8)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passes++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic bi);
        iv8 = v; a8 = a; b8 = b; bin8 = bi;
    endtask

    task automatic check8(input string tag, input logic ov, input logic [7:0] d, input logic bo);
        check({tag, "_ov"}, 64'(ov8), 64'(ov));
        check({tag, "_d"}, 64'(d8), 64'(d));
        check({tag, "_bout"}, 64'(bout8), 64'(bo));
    endtask

    // Truth table bit k, with k = {a, b, bin}.
    logic [7:0] tt_d    = 8'b1001_0110;
    logic [7:0] tt_bout = 8'b1000_1110;

    initial begin
        logic [7:0] md;
        logic       mb;
        logic [8:0] r;
        logic       rv;
        logic [7:0] ra, rb;
        logic       rbin;

        rst = 1'b1;
        iv1 = 1'b1; a1 = 1'b1; b1 = 1'b0; bin1 = 1'b0;
        drive8(1'b1, 8'h55, 8'h11, 1'b0);
        step();
        check("rst_w1_ov", 64'(ov1), 64'd0);
        check("rst_w1_d", 64'(d1), 64'd0);
        check("rst_w1_bout", 64'(bout1), 64'd0);
        check8("rst_w8", 1'b0, 8'h00, 1'b0);

        rst = 1'b0;
        iv8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            iv1 = 1'b1; a1 = k[2]; b1 = k[1]; bin1 = k[0];
            step();
            check($sformatf("tt%0d_ov", k), 64'(ov1), 64'd1);
            check($sformatf("tt%0d_d", k), 64'(d1), 64'(tt_d[k]));
            check($sformatf("tt%0d_bout", k), 64'(bout1), 64'(tt_bout[k]));
        end
        iv1 = 1'b0; a1 = 1'b0; b1 = 1'b1; bin1 = 1'b0;
        step();
        check("w1_hold_ov", 64'(ov1), 64'd0);
        check("w1_hold_d", 64'(d1), 64'd1);
        check("w1_hold_bout", 64'(bout1), 64'd1);

        drive8(1'b1, 8'h00, 8'h01, 1'b0);
        step();
        check8("w8_00m01", 1'b1, 8'hFF, 1'b1);
        drive8(1'b1, 8'hFF, 8'hFF, 1'b1);
        step();
        check8("w8_FFmFFm1", 1'b1, 8'hFF, 1'b1);
        drive8(1'b1, 8'h80, 8'h7F, 1'b1);
        step();
        check8("w8_80m7Fm1", 1'b1, 8'h00, 1'b0);

        drive8(1'b1, 8'h0A, 8'h05, 1'b0);
        step();
        check8("hold_load", 1'b1, 8'h05, 1'b0);
        drive8(1'b0, 8'h33, 8'h77, 1'b1);
        step();
        check8("hold1", 1'b0, 8'h05, 1'b0);
        drive8(1'b0, 8'h00, 8'hFF, 1'b0);
        step();
        check8("hold2", 1'b0, 8'h05, 1'b0);

        rst = 1'b1;
        drive8(1'b1, 8'h10, 8'h20, 1'b0);
        step();
        check8("midrst", 1'b0, 8'h00, 1'b0);
        rst = 1'b0;
        drive8(1'b1, 8'h03, 8'h01, 1'b0);
        step();
        check8("post_rst", 1'b1, 8'h02, 1'b0);

        md = 8'h02;
        mb = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            rv   = 1'($urandom_range(0, 3) != 0);
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rbin = 1'($urandom);
            drive8(rv, ra, rb, rbin);
            if (rv) begin
                r  = {1'b0, ra} - {1'b0, rb} - {8'd0, rbin};
                md = r[7:0];
                mb = r[8];
            end
            step();
            check8($sformatf("rnd%0d", n), rv, md, mb);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
